// File: rtl/lzx_cs_pkg.sv
// Shared types and constants for the chip-select scheduler and its
// rotating-priority picker.
package lzx_cs_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    GUARD
  } state_t;

  // Pin levels for the 74HC138 enable inputs.
  typedef struct packed {
    logic e1_n;
    logic e2_n;
    logic e3;
  } dec_en_t;

  localparam dec_en_t DEC_ON  = '{e1_n: 1'b0, e2_n: 1'b0, e3: 1'b1};
  localparam dec_en_t DEC_OFF = '{e1_n: 1'b1, e2_n: 1'b1, e3: 1'b0};

endpackage

// File: rtl/lzx_rr_pick8.sv
// Combinational rotating-priority picker: first set request at or above
// ptr, wrapping from 7 back to 0.
module lzx_rr_pick8
  import lzx_cs_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // Index arithmetic wraps naturally in ID_W bits.
      cand = ptr + ID_W'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/lzx_cs_scheduler.sv
// Round-robin scheduler sharing one 3-to-8 decoder among 8 requesters,
// with address setup, bounded active window and guard gap per grant.
module lzx_cs_scheduler
  import lzx_cs_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 4,
  parameter int GUARD_CYC = 1,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [ID_W-1:0]  dec_a,
  output logic             dec_e1_n,
  output logic             dec_e2_n,
  output logic             dec_e3,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam state_t           POST_ST  = (GUARD_CYC > 0) ? GUARD : IDLE;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  dec_en_t            en_q, en_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;

  lzx_rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          id_d    = pick_idx;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // A released request aborts silently: no grant, no done.
        if (!req[id_q]) begin
          ptr_d   = id_q + ID_W'(1);
          cnt_d   = GUARD_LD;
          state_d = POST_ST;
        end else if (cnt_q == '0) begin
          en_d    = DEC_ON;
          gnt_d   = N_REQ'(1) << id_q;
          cnt_d   = HOLD_LD;
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q == '0 || !req[id_q]) begin
          en_d    = DEC_OFF;
          gnt_d   = '0;
          done_d  = 1'b1;
          ptr_d   = id_q + ID_W'(1);
          cnt_d   = GUARD_LD;
          state_d = POST_ST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GUARD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      en_q    <= DEC_OFF;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dec_a    = id_q;
  assign gnt_id   = id_q;
  assign dec_e1_n = en_q.e1_n;
  assign dec_e2_n = en_q.e2_n;
  assign dec_e3   = en_q.e3;
  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lzx_cs_scheduler.sv
// Self-checking bench for lzx_cs_scheduler: directed scenarios, a random
// transaction-level round-robin model, and a per-cycle invariant monitor.
module tb_lzx_cs_scheduler;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] dec_a;
  logic       dec_e1_n, dec_e2_n, dec_e3;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy, done;

  int tests = 0;
  int fails = 0;

  lzx_cs_scheduler #(
    .SETUP_CYC (1),
    .HOLD_CYC  (HOLD),
    .GUARD_CYC (1),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .dec_a    (dec_a),
    .dec_e1_n (dec_e1_n),
    .dec_e2_n (dec_e2_n),
    .dec_e3   (dec_e3),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle invariants, sampled on the falling edge.
  logic       prev_en;
  logic [2:0] prev_a;
  logic [7:0] prev_gnt;
  bit         pending;

  always @(negedge clk) begin
    logic en, off;
    logic [7:0] y_n;
    if (!rst_n) begin
      prev_en = 1'b0; prev_gnt = '0; pending = 0; prev_a = '0;
    end else begin
      en  = (dec_e1_n == 1'b0) && (dec_e2_n == 1'b0) && (dec_e3 == 1'b1);
      off = (dec_e1_n == 1'b1) && (dec_e2_n == 1'b1) && (dec_e3 == 1'b0);
      tests++;
      if (!(en || off)) begin
        fails++; $display("FAIL inv_enable_levels: e1_n=%b e2_n=%b e3=%b, need all-on or all-off", dec_e1_n, dec_e2_n, dec_e3);
      end
      tests++;
      if (((gnt & (gnt - 8'd1)) != 8'h00) || ((gnt != 8'h00) != en)) begin
        fails++; $display("FAIL inv_gnt_onehot: gnt=%h en=%b, need one-hot exactly when enabled", gnt, en);
      end
      y_n = en ? ~(8'h01 << dec_a) : 8'hFF;
      tests++;
      if (~y_n !== gnt) begin
        fails++; $display("FAIL inv_decoded_line: ~Y=%h gnt=%h, need equal", ~y_n, gnt);
      end
      if (prev_en && en) begin
        tests++;
        if (dec_a !== prev_a) begin
          fails++; $display("FAIL inv_addr_stable: dec_a=%0d was %0d while enabled", dec_a, prev_a);
        end
      end
      if (gnt != 8'h00 && prev_gnt == 8'h00) begin
        tests++;
        if (pending) begin
          fails++; $display("FAIL inv_done_per_grant: new grant %h before previous done", gnt);
        end
        pending = 1;
      end
      if (done) begin
        tests++;
        if (!pending) begin
          fails++; $display("FAIL inv_done_per_grant: done=1 with no outstanding grant, need 0");
        end
        pending = 0;
      end
      prev_en = en; prev_a = dec_a; prev_gnt = gnt;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [7:0] r);
    rst_n = 1'b0;
    req   = r;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy !== 1'b0 && w < 100) begin
      @(negedge clk); w++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, w);
    end
  endtask

  // Waits for a grant, records its index and length; optionally drops req
  // during the stop_after-th active cycle. Leaves time at the first
  // sample after the window (the done cycle).
  task automatic measure(input int stop_after, output int gap, output int idx,
                         output int len);
    gap = 0; idx = -1; len = 0;
    while (gnt == 8'h00 && gap < 200) begin
      @(negedge clk); gap++;
    end
    if (gnt == 8'h00) return;
    for (int i = 0; i < 8; i++) if (gnt[i]) idx = i;
    while (gnt != 8'h00 && len < 200) begin
      len++;
      if (len == stop_after) req = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    tests++;
    if (dec_a !== 3'd0 || dec_e1_n !== 1'b1 || dec_e2_n !== 1'b1 || dec_e3 !== 1'b0 ||
        gnt !== 8'h00 || gnt_id !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: a=%0d e1_n=%b e2_n=%b e3=%b gnt=%h id=%0d busy=%b done=%b, need 0,1,1,0,00,0,0,0",
               dec_a, dec_e1_n, dec_e2_n, dec_e3, gnt, gnt_id, busy, done);
    end
  endtask

  task automatic test_single();
    do_reset(8'h00);
    req = 8'h20;
    @(negedge clk);
    tests++;
    if (dec_a !== 3'd5 || gnt_id !== 3'd5 || busy !== 1'b1 || gnt !== 8'h00 || dec_e3 !== 1'b0) begin
      fails++; $display("FAIL single_setup: a=%0d id=%0d busy=%b gnt=%h e3=%b, need 5,5,1,00,0", dec_a, gnt_id, busy, gnt, dec_e3);
    end
    for (int t = 2; t <= 5; t++) begin
      @(negedge clk);
      tests++;
      if (gnt !== 8'h20 || dec_e1_n !== 1'b0 || dec_e2_n !== 1'b0 || dec_e3 !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL single_active_t%0d: gnt=%h e=%b%b%b done=%b, need 20,001,0", t, gnt, dec_e1_n, dec_e2_n, dec_e3, done);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || gnt !== 8'h00 || dec_e1_n !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL single_done_t6: done=%b gnt=%h e1_n=%b busy=%b, need 1,00,1,1", done, gnt, dec_e1_n, busy);
    end
    req = 8'h61;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL single_idle_t7: busy=%b done=%b, need 0,0", busy, done);
    end
    @(negedge clk);
    tests++;
    if (dec_a !== 3'd6) begin
      fails++; $display("FAIL single_ptr6: next winner=%0d, need 6", dec_a);
    end
    req = 8'h00;
    wait_idle();
  endtask

  task automatic test_all_ff();
    int gap, idx, len;
    do_reset(8'hFF);
    for (int k = 0; k <= 8; k++) begin
      measure(0, gap, idx, len);
      tests++;
      if (idx !== (k % 8) || len !== HOLD || (k > 0 && gap !== 3) || done !== 1'b1) begin
        fails++; $display("FAIL all_ff_grant%0d: idx=%0d len=%0d gap=%0d done=%b, need %0d,%0d,3,1", k, idx, len, gap, done, k % 8, HOLD);
      end
    end
    req = 8'h00;
    wait_idle();
  endtask

  task automatic test_early_release();
    int gap, idx, len;
    do_reset(8'h00);
    req = 8'h08;
    measure(2, gap, idx, len);
    tests++;
    if (idx !== 3 || len !== 2 || done !== 1'b1 || dec_e3 !== 1'b0 || gnt !== 8'h00) begin
      fails++; $display("FAIL early_release: idx=%0d len=%0d done=%b e3=%b gnt=%h, need 3,2,1,0,00", idx, len, done, dec_e3, gnt);
    end
    wait_idle();
  endtask

  task automatic test_abort();
    do_reset(8'h00);
    req = 8'h04;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || dec_a !== 3'd2) begin
      fails++; $display("FAIL abort_setup: busy=%b a=%0d, need 1,2", busy, dec_a);
    end
    req = 8'h00;
    @(negedge clk);
    tests++;
    if (gnt !== 8'h00 || done !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL abort_guard: gnt=%h done=%b busy=%b, need 00,0,1", gnt, done, busy);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || gnt !== 8'h00) begin
      fails++; $display("FAIL abort_idle: busy=%b done=%b gnt=%h, need 0,0,00", busy, done, gnt);
    end
    req = 8'h0C;
    @(negedge clk);
    tests++;
    if (dec_a !== 3'd3) begin
      fails++; $display("FAIL abort_ptr3: next winner=%0d, need 3", dec_a);
    end
    req = 8'h00;
    wait_idle();
  endtask

  task automatic test_wrap();
    int gap, idx, len;
    do_reset(8'h00);
    req = 8'h40;
    measure(0, gap, idx, len);
    tests++;
    if (idx !== 6) begin
      fails++; $display("FAIL wrap_pre: idx=%0d, need 6", idx);
    end
    req = 8'h81;
    measure(0, gap, idx, len);
    tests++;
    if (idx !== 7 || len !== HOLD) begin
      fails++; $display("FAIL wrap_first: idx=%0d len=%0d, need 7,%0d", idx, len, HOLD);
    end
    measure(0, gap, idx, len);
    tests++;
    if (idx !== 0 || len !== HOLD) begin
      fails++; $display("FAIL wrap_second: idx=%0d len=%0d, need 0,%0d", idx, len, HOLD);
    end
    req = 8'h00;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int w = 0;
    int gap, idx, len;
    do_reset(8'h00);
    req = 8'h10;
    while (gnt == 8'h00 && w < 50) begin
      @(negedge clk); w++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (dec_e1_n !== 1'b1 || dec_e2_n !== 1'b1 || dec_e3 !== 1'b0 || gnt !== 8'h00 ||
        busy !== 1'b0 || done !== 1'b0 || dec_a !== 3'd0) begin
      fails++; $display("FAIL reset_mid_async: e=%b%b%b gnt=%h busy=%b done=%b a=%0d, need 110,00,0,0,0",
                        dec_e1_n, dec_e2_n, dec_e3, gnt, busy, done, dec_a);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h06;
    measure(0, gap, idx, len);
    tests++;
    if (idx !== 1) begin
      fails++; $display("FAIL reset_mid_restart: idx=%0d, need 1", idx);
    end
    req = 8'h00;
    wait_idle();
  endtask

  // Random transactions against a round-robin model kept as a bare pointer.
  task automatic test_random();
    int model_ptr = 0;
    int gap, idx, len, win, k;
    logic [7:0] pat;
    do_reset(8'h00);
    for (int n = 0; n < 40; n++) begin
      pat = 8'($urandom_range(1, 255));
      k   = $urandom_range(1, HOLD);
      win = -1;
      for (int o = 0; o < 8; o++) begin
        if (win < 0 && pat[(model_ptr + o) % 8]) win = (model_ptr + o) % 8;
      end
      req = pat;
      measure((k == HOLD) ? 0 : k, gap, idx, len);
      tests++;
      if (idx !== win || len !== k || done !== 1'b1) begin
        fails++; $display("FAIL random_%0d: req=%h idx=%0d len=%0d done=%b, need %0d,%0d,1", n, pat, idx, len, done, win, k);
      end
      model_ptr = (win + 1) % 8;
      req = 8'h00;
      wait_idle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    test_reset();
    test_single();
    test_all_ff();
    test_early_release();
    test_abort();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
